// File: rtl/jtframe_dump_trigger.sv
// Frame counter and dump window sequencer for the simulation dump block.
// Turns VS falls and the ROM download flag into frame/window strobes.
module jtframe_dump_trigger #(
  parameter int unsigned LOADROM     = 0,
  parameter logic [31:0] DUMP_START  = 32'd0,
  parameter logic [31:0] DUMP_FRAMES = 32'd0,
  parameter logic [31:0] MAX_FRAMES  = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        downloading,
  output logic [31:0] frame_cnt,
  output logic        vs_fall,
  output logic        dump_on,
  output logic        dump_off,
  output logic        dumping,
  output logic        sim_done
);

  localparam logic [1:0] WAIT_DL    = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] DUMPING    = 2'd2;
  localparam logic [1:0] STOPPED    = 2'd3;

  localparam logic [1:0] IDLE_ST =
    (LOADROM != 0) ? WAIT_DL : WAIT_START;

  localparam logic START_ZERO = (DUMP_START == 32'd0);
  localparam logic STOP_EN    = (DUMP_FRAMES != 32'd0);
  localparam logic DONE_EN    = (MAX_FRAMES != 32'd0);

  logic        vs_l;
  logic        dl_l;
  logic        fall;
  logic        dl_rise;
  logic        dl_end;
  logic        cnt_ev;
  logic        start_hit;
  logic [31:0] frame_nxt;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        on_nxt;
  logic        off_nxt;
  logic [31:0] win_cnt;
  logic [31:0] win_nxt;
  logic [31:0] win_inc;

  // Previous-cycle copies of vs and downloading for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_l <= 1'b1;
      dl_l <= 1'b0;
    end else begin
      vs_l <= vs;
      dl_l <= downloading;
    end
  end

  // Edge strobes; a fall during a download is never counted
  always_comb begin
    fall    = vs_l & ~vs;
    dl_rise = ~dl_l & downloading;
    dl_end  = dl_l & ~downloading;
    cnt_ev  = fall & ~downloading;
  end

  // Next frame count: cleared while downloading, saturating increment
  always_comb begin
    frame_nxt = frame_cnt;
    if (downloading) begin
      frame_nxt = 32'd0;
    end else if (fall && frame_cnt != 32'hFFFF_FFFF) begin
      frame_nxt = frame_cnt + 32'd1;
    end
  end

  // Window progress counter, saturating so it can never wrap to a match
  always_comb begin
    win_inc = win_cnt;
    if (win_cnt != 32'hFFFF_FFFF) begin
      win_inc = win_cnt + 32'd1;
    end
  end

  // A counted fall landing exactly on the start frame
  always_comb begin
    start_hit = cnt_ev && (frame_nxt == DUMP_START);
  end

  // Frame counter and per-frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 32'd0;
      vs_fall   <= 1'b0;
    end else begin
      frame_cnt <= frame_nxt;
      vs_fall   <= cnt_ev;
    end
  end

  // Window sequencer: a new download always restarts the sequence
  always_comb begin
    state_nxt = state;
    on_nxt    = 1'b0;
    off_nxt   = 1'b0;
    win_nxt   = win_cnt;
    unique case (state)
      WAIT_DL: begin
        if (dl_end) begin
          if (START_ZERO || start_hit) begin
            state_nxt = DUMPING;
            on_nxt    = 1'b1;
            win_nxt   = 32'd0;
          end else begin
            state_nxt = WAIT_START;
          end
        end
      end
      WAIT_START: begin
        if (dl_rise) begin
          state_nxt = IDLE_ST;
        end else if ((START_ZERO && !downloading)
                     || start_hit) begin
          state_nxt = DUMPING;
          on_nxt    = 1'b1;
          win_nxt   = 32'd0;
        end
      end
      DUMPING: begin
        if (dl_rise) begin
          state_nxt = IDLE_ST;
          off_nxt   = 1'b1;
        end else if (cnt_ev) begin
          win_nxt = win_inc;
          if (STOP_EN && win_inc == DUMP_FRAMES) begin
            state_nxt = STOPPED;
            off_nxt   = 1'b1;
          end
        end
      end
      STOPPED: begin
        if (dl_rise) begin
          state_nxt = IDLE_ST;
        end
      end
      default: begin
        state_nxt = IDLE_ST;
      end
    endcase
  end

  // Sequencer registers and window strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE_ST;
      win_cnt  <= 32'd0;
      dump_on  <= 1'b0;
      dump_off <= 1'b0;
      dumping  <= 1'b0;
    end else begin
      state    <= state_nxt;
      win_cnt  <= win_nxt;
      dump_on  <= on_nxt;
      dump_off <= off_nxt;
      dumping  <= (state_nxt == DUMPING);
    end
  end

  // Sticky end-of-run request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_done <= 1'b0;
    end else if (DONE_EN && frame_nxt == MAX_FRAMES) begin
      sim_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_dump_trigger.sv
// Bench for jtframe_dump_trigger: four parameter sets on shared inputs,
// directed scenarios plus random stimulus against a frame-level model.
module tb_jtframe_dump_trigger;

  localparam int NI = 4;
  localparam int LR [NI] = '{0, 1, 0, 1};
  localparam int DS [NI] = '{3, 0, 2, 2};
  localparam int DF [NI] = '{0, 0, 4, 3};
  localparam int MF [NI] = '{10, 0, 0, 7};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b1;
  logic        downloading = 1'b0;
  logic [31:0] fc   [NI];
  logic        vsf  [NI];
  logic        don  [NI];
  logic        doff [NI];
  logic        dmp  [NI];
  logic        sdn  [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtframe_dump_trigger #(
    .LOADROM(0), .DUMP_START(3), .DUMP_FRAMES(0), .MAX_FRAMES(10)
  ) u0 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(fc[0]), .vs_fall(vsf[0]), .dump_on(don[0]),
    .dump_off(doff[0]), .dumping(dmp[0]), .sim_done(sdn[0])
  );

  jtframe_dump_trigger #(
    .LOADROM(1), .DUMP_START(0), .DUMP_FRAMES(0), .MAX_FRAMES(0)
  ) u1 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(fc[1]), .vs_fall(vsf[1]), .dump_on(don[1]),
    .dump_off(doff[1]), .dumping(dmp[1]), .sim_done(sdn[1])
  );

  jtframe_dump_trigger #(
    .LOADROM(0), .DUMP_START(2), .DUMP_FRAMES(4), .MAX_FRAMES(0)
  ) u2 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(fc[2]), .vs_fall(vsf[2]), .dump_on(don[2]),
    .dump_off(doff[2]), .dumping(dmp[2]), .sim_done(sdn[2])
  );

  jtframe_dump_trigger #(
    .LOADROM(1), .DUMP_START(2), .DUMP_FRAMES(3), .MAX_FRAMES(7)
  ) u3 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(fc[3]), .vs_fall(vsf[3]), .dump_on(don[3]),
    .dump_off(doff[3]), .dumping(dmp[3]), .sim_done(sdn[3])
  );

  // Reference model: frames, and a window opened/closed by frame numbers
  int unsigned m_frame [NI];
  int unsigned m_open_at [NI];
  bit m_vsf [NI];
  bit m_on [NI];
  bit m_off [NI];
  bit m_dump [NI];
  bit m_done [NI];
  bit m_armed [NI];
  bit m_closed [NI];
  bit m_vsp;
  bit m_dlp;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_frame[i] = 0;
      m_open_at[i] = 0;
      m_vsf[i] = 0;
      m_on[i] = 0;
      m_off[i] = 0;
      m_dump[i] = 0;
      m_done[i] = 0;
      m_closed[i] = 0;
      m_armed[i] = (LR[i] == 0);
    end
    m_vsp = 1;
    m_dlp = 0;
  endtask

  task automatic model_open(input int i);
    m_dump[i] = 1;
    m_on[i] = 1;
    m_open_at[i] = m_frame[i];
  endtask

  task automatic model_clock();
    bit fall, rise, dend, cnt;
    fall = m_vsp && !vs;
    rise = !m_dlp && downloading;
    dend = m_dlp && !downloading;
    cnt = fall && !downloading;
    for (int i = 0; i < NI; i++) begin
      m_vsf[i] = 0;
      m_on[i] = 0;
      m_off[i] = 0;
      if (downloading) begin
        m_frame[i] = 0;
      end else if (fall) begin
        if (m_frame[i] != 32'hFFFF_FFFF) m_frame[i]++;
        m_vsf[i] = 1;
      end
      if (rise) begin
        if (m_dump[i]) m_off[i] = 1;
        m_dump[i] = 0;
        m_closed[i] = 0;
        m_armed[i] = (LR[i] == 0);
      end else if (!m_armed[i]) begin
        if (dend) begin
          m_armed[i] = 1;
          if (DS[i] == 0 || (cnt && m_frame[i] == DS[i]))
            model_open(i);
        end
      end else if (!m_dump[i] && !m_closed[i]) begin
        if ((DS[i] == 0 && !downloading)
            || (cnt && m_frame[i] == DS[i]))
          model_open(i);
      end else if (m_dump[i]) begin
        if (DF[i] != 0 && cnt
            && m_frame[i] - m_open_at[i] == DF[i]) begin
          m_dump[i] = 0;
          m_closed[i] = 1;
          m_off[i] = 1;
        end
      end
      if (MF[i] != 0 && m_frame[i] == MF[i]) m_done[i] = 1;
    end
    m_vsp = vs;
    m_dlp = downloading;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vs = 1'b1;
    downloading = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic vs_restore();
    step();
    vs = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (fc[i] !== 32'd0 || vsf[i] !== 1'b0 || don[i] !== 1'b0
          || doff[i] !== 1'b0 || dmp[i] !== 1'b0 || sdn[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset inst%0d fc=%0h vsf=%b on=%b off=%b dmp=%b done=%b exp all 0",
                 i, fc[i], vsf[i], don[i], doff[i], dmp[i], sdn[i]);
      end
    end
  endtask

  task automatic test_start_frame();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      vs = 1'b0;
      step();
      checks++;
      if (fc[0] !== 32'(k) || vsf[0] !== 1'b1) begin
        failures++;
        $display("FAIL start_cnt k=%0d got fc=%0d vsf=%b exp fc=%0d vsf=1",
                 k, fc[0], vsf[0], k);
      end
      checks++;
      if (don[0] !== (k == 3) || dmp[0] !== (k >= 3)) begin
        failures++;
        $display("FAIL start_on k=%0d got on=%b dmp=%b exp on=%b dmp=%b",
                 k, don[0], dmp[0], k == 3, k >= 3);
      end
      vs_restore();
      checks++;
      if (vsf[0] !== 1'b0 || don[0] !== 1'b0 || dmp[0] !== (k >= 3)) begin
        failures++;
        $display("FAIL start_idle k=%0d got vsf=%b on=%b dmp=%b",
                 k, vsf[0], don[0], dmp[0]);
      end
    end
  endtask

  task automatic test_download();
    do_reset();
    downloading = 1'b1;
    step();
    vs = 1'b0;
    step();
    checks++;
    if (vsf[1] !== 1'b0 || fc[1] !== 32'd0 || vsf[0] !== 1'b0
        || fc[0] !== 32'd0) begin
      failures++;
      $display("FAIL dl_hold got vsf=%b/%b fc=%0d/%0d exp 0",
               vsf[1], vsf[0], fc[1], fc[0]);
    end
    vs_restore();
    downloading = 1'b0;
    step();
    checks++;
    if (don[1] !== 1'b1 || dmp[1] !== 1'b1 || fc[1] !== 32'd0) begin
      failures++;
      $display("FAIL dl_end_on got on=%b dmp=%b fc=%0d exp on=1 dmp=1 fc=0",
               don[1], dmp[1], fc[1]);
    end
    step();
    checks++;
    if (don[1] !== 1'b0 || dmp[1] !== 1'b1) begin
      failures++;
      $display("FAIL dl_end_after got on=%b dmp=%b exp on=0 dmp=1",
               don[1], dmp[1]);
    end
  endtask

  task automatic test_window();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      vs = 1'b0;
      step();
      checks++;
      if (don[2] !== (k == 2) || doff[2] !== (k == 6)
          || dmp[2] !== (k >= 2 && k < 6)) begin
        failures++;
        $display("FAIL window k=%0d got on=%b off=%b dmp=%b exp %b %b %b",
                 k, don[2], doff[2], dmp[2], k == 2, k == 6,
                 k >= 2 && k < 6);
      end
      vs_restore();
    end
  endtask

  task automatic test_max_frames();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      vs = 1'b0;
      step();
      checks++;
      if (sdn[0] !== (k >= 10) || fc[0] !== 32'(k)) begin
        failures++;
        $display("FAIL max_frames k=%0d got done=%b fc=%0d exp done=%b",
                 k, sdn[0], fc[0], k >= 10);
      end
      vs_restore();
    end
  endtask

  task automatic test_coincident();
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      vs = 1'b0;
      step();
      vs_restore();
    end
    vs = 1'b0;
    downloading = 1'b1;
    step();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (fc[i] !== 32'd0 || vsf[i] !== 1'b0 || don[i] !== 1'b0) begin
        failures++;
        $display("FAIL coincident inst%0d got fc=%0d vsf=%b on=%b exp 0",
                 i, fc[i], vsf[i], don[i]);
      end
    end
    checks++;
    if (doff[2] !== 1'b1 || dmp[2] !== 1'b0) begin
      failures++;
      $display("FAIL new_dl_close got off=%b dmp=%b exp off=1 dmp=0",
               doff[2], dmp[2]);
    end
    step();
    vs = 1'b1;
    downloading = 1'b0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      vs = 1'b0;
      step();
      vs_restore();
    end
    checks++;
    if (dmp[0] !== 1'b1 || dmp[2] !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst got dmp0=%b dmp2=%b exp 1 1", dmp[0], dmp[2]);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (fc[i] !== 32'd0 || vsf[i] !== 1'b0 || don[i] !== 1'b0
          || doff[i] !== 1'b0 || dmp[i] !== 1'b0 || sdn[i] !== 1'b0) begin
        failures++;
        $display("FAIL async_rst inst%0d fc=%0d vsf=%b on=%b off=%b dmp=%b done=%b",
                 i, fc[i], vsf[i], don[i], doff[i], dmp[i], sdn[i]);
      end
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (doff[i] !== 1'b0 || dmp[i] !== 1'b0) begin
          failures++;
          $display("FAIL rst_hold inst%0d got off=%b dmp=%b exp 0 0",
                   i, doff[i], dmp[i]);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(2, 0) == 0) vs = ~vs;
      if (!downloading && $urandom_range(199, 0) == 0)
        downloading = 1'b1;
      else if (downloading && $urandom_range(7, 0) == 0)
        downloading = 1'b0;
      step();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (fc[i] !== m_frame[i]) begin
          failures++;
          $display("FAIL rnd_frame c=%0d inst%0d got %0d exp %0d",
                   c, i, fc[i], m_frame[i]);
        end
        checks++;
        if (vsf[i] !== m_vsf[i]) begin
          failures++;
          $display("FAIL rnd_vsf c=%0d inst%0d got %b exp %b",
                   c, i, vsf[i], m_vsf[i]);
        end
        checks++;
        if (don[i] !== m_on[i]) begin
          failures++;
          $display("FAIL rnd_on c=%0d inst%0d got %b exp %b",
                   c, i, don[i], m_on[i]);
        end
        checks++;
        if (doff[i] !== m_off[i]) begin
          failures++;
          $display("FAIL rnd_off c=%0d inst%0d got %b exp %b",
                   c, i, doff[i], m_off[i]);
        end
        checks++;
        if (dmp[i] !== m_dump[i]) begin
          failures++;
          $display("FAIL rnd_dumping c=%0d inst%0d got %b exp %b",
                   c, i, dmp[i], m_dump[i]);
        end
        checks++;
        if (sdn[i] !== m_done[i]) begin
          failures++;
          $display("FAIL rnd_done c=%0d inst%0d got %b exp %b",
                   c, i, sdn[i], m_done[i]);
        end
        checks++;
        if (don[i] === 1'b1 && doff[i] === 1'b1) begin
          failures++;
          $display("FAIL rnd_on_off c=%0d inst%0d got both=1 exp not both",
                   c, i);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_frame();
    test_download();
    test_window();
    test_max_frames();
    test_coincident();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
